// File: rtl/aclk_timegen.sv
// aclk_timegen: divides clk into one-cycle one_second/one_minute strobes with fast-watch and restart
module aclk_timegen #(
  parameter int CLKS_PER_SEC = 256,
  parameter int SECS_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_count,
  input  logic       fast_watch,
  output logic       one_second,
  output logic       one_minute,
  output logic [5:0] sec_count
);
  localparam int PW = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] P_MAX = PW'(CLKS_PER_SEC - 1);
  localparam logic [5:0] S_MAX = 6'(SECS_PER_MIN - 1);
  logic [PW-1:0] p;
  logic sec_tick, min_tick;
  // wrap detection for prescaler and second counter
  always_comb begin
    sec_tick = p == P_MAX;
    min_tick = sec_tick && sec_count == S_MAX;
  end
  // prescaler, second counter and registered strobes; restart clears like reset
  always_ff @(posedge clk) begin
    if (reset || reset_count) begin
      p <= '0;
      sec_count <= '0;
      one_second <= 1'b0;
      one_minute <= 1'b0;
    end else begin
      p <= sec_tick ? '0 : p + 1'b1;
      if (sec_tick) sec_count <= min_tick ? '0 : sec_count + 6'd1;
      one_second <= sec_tick;
      one_minute <= fast_watch ? sec_tick : min_tick;
    end
  end
endmodule
